fifo_wr_arbiter: RTL and testbench

FIFO_WR_ARBITER -- requirements
Module: fifo_wr_arbiter

---
 rtl/fifo_wr_arbiter.sv | 154 +++++++++++++++
 tb/tb_fifo_wr_arbiter.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_wr_arbiter.sv
// Round-robin write arbiter: N_REQ bursty requesters share one asynchronous-FIFO write port.
// Ownership is registered; beats pass combinationally while the owner is valid and the FIFO has room.
module fifo_wr_arbiter #(
  parameter int unsigned N_REQ       = 4,
  parameter int unsigned DATA_WIDTH  = 8,
  parameter int unsigned MAX_BURST   = 16,
  parameter int unsigned STALL_LIMIT = 64
) (
  input  logic                        wclk,
  input  logic                        wrst_n,
  input  logic [N_REQ-1:0]            req_valid,
  input  logic [N_REQ*DATA_WIDTH-1:0] req_data,
  input  logic [N_REQ-1:0]            req_last,
  output logic [N_REQ-1:0]            req_ready,
  input  logic                        full,
  output logic                        w_en,
  output logic [DATA_WIDTH-1:0]       data_in,
  output logic [N_REQ-1:0]            grant,
  output logic                        stall_err,
  input  logic                        err_clr
);

  localparam int unsigned IdxW   = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int unsigned BeatW  = $clog2(MAX_BURST + 1);
  localparam int unsigned StallW = $clog2(STALL_LIMIT + 1);

  typedef enum logic {StIdle, StBurst} state_e;

  state_e             state_q, state_d;
  logic [N_REQ-1:0]   grant_q, grant_d;
  logic [IdxW-1:0]    owner_q, owner_d;
  logic [IdxW-1:0]    rr_ptr_q, rr_ptr_d;
  logic [BeatW-1:0]   beat_cnt_q, beat_cnt_d;
  logic [StallW-1:0]  stall_cnt_q, stall_cnt_d;
  logic               stall_err_q, stall_err_d;
  logic               arm_q, arm_d;

  logic               win_found;
  logic [IdxW-1:0]    win_idx;
  logic [IdxW-1:0]    cand;
  logic               owner_valid;
  logic               owner_last;
  logic               stall_set;
  logic               fire;

  // Round-robin search upward from rr_ptr, wrapping at N_REQ-1.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      cand = IdxW'((32'(rr_ptr_q) + k) % N_REQ);
      if (!win_found && req_valid[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  assign owner_valid = req_valid[owner_q];
  assign owner_last  = req_last[owner_q];

  // grant_q is cleared asynchronously, so these are also quiet during reset.
  assign req_ready = grant_q & {N_REQ{~full}};
  assign fire      = |(req_valid & req_ready);
  assign w_en      = fire;
  assign grant     = grant_q;
  assign stall_err = stall_err_q;

  always_comb begin
    data_in = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (grant_q[i]) begin
        data_in = req_data[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    owner_d     = owner_q;
    rr_ptr_d    = rr_ptr_q;
    beat_cnt_d  = beat_cnt_q;
    stall_cnt_d = '0;
    stall_set   = 1'b0;
    // Holds off arbitration for one edge after reset release.
    arm_d       = 1'b1;

    unique case (state_q)
      StIdle: begin
        if (arm_q && win_found) begin
          state_d    = StBurst;
          owner_d    = win_idx;
          beat_cnt_d = '0;
          for (int unsigned i = 0; i < N_REQ; i++) begin
            grant_d[i] = (IdxW'(i) == win_idx);
          end
        end
      end
      StBurst: begin
        if (owner_valid && full) begin
          if (stall_cnt_q == StallW'(STALL_LIMIT)) begin
            stall_cnt_d = stall_cnt_q;
          end else begin
            stall_cnt_d = stall_cnt_q + 1'b1;
            stall_set   = (stall_cnt_q == StallW'(STALL_LIMIT - 1));
          end
        end
        if (fire) begin
          beat_cnt_d = beat_cnt_q + 1'b1;
          if (owner_last || (beat_cnt_q == BeatW'(MAX_BURST - 1))) begin
            state_d  = StIdle;
            grant_d  = '0;
            rr_ptr_d = (32'(owner_q) == N_REQ - 1) ? '0 : owner_q + 1'b1;
          end
        end
      end
      default: state_d = StIdle;
    endcase

    // A new stall detection outranks a simultaneous clear.
    if (stall_set) begin
      stall_err_d = 1'b1;
    end else if (err_clr) begin
      stall_err_d = 1'b0;
    end else begin
      stall_err_d = stall_err_q;
    end
  end

  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      state_q     <= StIdle;
      grant_q     <= '0;
      owner_q     <= '0;
      rr_ptr_q    <= '0;
      beat_cnt_q  <= '0;
      stall_cnt_q <= '0;
      stall_err_q <= 1'b0;
      arm_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      owner_q     <= owner_d;
      rr_ptr_q    <= rr_ptr_d;
      beat_cnt_q  <= beat_cnt_d;
      stall_cnt_q <= stall_cnt_d;
      stall_err_q <= stall_err_d;
      arm_q       <= arm_d;
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter: reset, single burst, round-robin, burst cap,
// backpressure, stall error and reset mid-burst, all with hand-computed expectations.
module tb_fifo_wr_arbiter;

  localparam int unsigned NReq = 4;
  localparam int unsigned Dw   = 8;

  logic              wclk = 1'b0;
  logic              wrst_n;
  logic [NReq-1:0]   req_valid;
  logic [NReq*Dw-1:0] req_data;
  logic [NReq-1:0]   req_last;
  logic [NReq-1:0]   req_ready;
  logic              full;
  logic              w_en;
  logic [Dw-1:0]     data_in;
  logic [NReq-1:0]   grant;
  logic              stall_err;
  logic              err_clr;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  logic [3:0] exp_g [5];
  logic [7:0] exp_d [5];
  int unsigned cnt;
  int unsigned bad;
  int unsigned rise_at;

  fifo_wr_arbiter #(
    .N_REQ      (NReq),
    .DATA_WIDTH (Dw),
    .MAX_BURST  (16),
    .STALL_LIMIT(64)
  ) dut (
    .wclk      (wclk),
    .wrst_n    (wrst_n),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_last  (req_last),
    .req_ready (req_ready),
    .full      (full),
    .w_en      (w_en),
    .data_in   (data_in),
    .grant     (grant),
    .stall_err (stall_err),
    .err_clr   (err_clr)
  );

  always #5 wclk = ~wclk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge wclk);
    #2;
  endtask

  initial begin
    exp_g = '{4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010};
    exp_d = '{8'h22, 8'h33, 8'h44, 8'h11, 8'h22};

    wrst_n    = 1'b0;
    req_valid = 4'b0001;
    req_data  = '0;
    req_data[7:0] = 8'hA1;
    req_last  = '0;
    full      = 1'b0;
    err_clr   = 1'b0;
    #3;
    chk("rst_grant", 32'(grant), 32'h0);
    chk("rst_w_en", 32'(w_en), 32'h0);
    chk("rst_ready", 32'(req_ready), 32'h0);
    chk("rst_data_in", 32'(data_in), 32'h0);
    chk("rst_stall_err", 32'(stall_err), 32'h0);

    // Release mid-cycle; first grant only on the second edge after release.
    tick();
    tick();
    wrst_n = 1'b1;
    tick();
    #1;
    chk("rel_edge1_grant", 32'(grant), 32'h0);
    chk("rel_edge1_w_en", 32'(w_en), 32'h0);
    tick();
    #1;
    chk("single_grant", 32'(grant), 32'b0001);
    chk("single_b1_w_en", 32'(w_en), 32'h1);
    chk("single_b1_data", 32'(data_in), 32'hA1);
    tick();
    req_data[7:0] = 8'hA2;
    #1;
    chk("single_b2_w_en", 32'(w_en), 32'h1);
    chk("single_b2_data", 32'(data_in), 32'hA2);
    tick();
    req_data[7:0] = 8'hA3;
    req_last      = 4'b0001;
    #1;
    chk("single_b3_w_en", 32'(w_en), 32'h1);
    chk("single_b3_data", 32'(data_in), 32'hA3);
    tick();
    req_valid = '0;
    req_last  = '0;
    #1;
    chk("single_idle_grant", 32'(grant), 32'h0);
    chk("single_idle_w_en", 32'(w_en), 32'h0);

    // Round-robin with one-beat bursts; rr_ptr is 1 after the single burst.
    req_valid = 4'b1111;
    req_last  = 4'b1111;
    req_data  = {8'h44, 8'h33, 8'h22, 8'h11};
    for (int i = 0; i < 5; i++) begin
      tick();
      #1;
      chk("rr_grant", 32'(grant), 32'(exp_g[i]));
      chk("rr_data", 32'(data_in), 32'(exp_d[i]));
      chk("rr_w_en", 32'(w_en), 32'h1);
      tick();
      #1;
      chk("rr_idle_grant", 32'(grant), 32'h0);
    end
    req_valid = '0;

    // Burst cap: requester 2 streams without last; requester 3 waits with a one-beat burst.
    req_valid = 4'b1100;
    req_last  = 4'b1000;
    req_data[23:16] = 8'h50;
    tick();
    #1;
    chk("cap_grant", 32'(grant), 32'b0100);
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      if (w_en && grant == 4'b0100) cnt++;
      if (i == 15) break;
      tick();
      #1;
    end
    tick();
    #1;
    chk("cap_beats", cnt, 32'd16);
    chk("cap_idle_grant", 32'(grant), 32'h0);
    chk("cap_idle_w_en", 32'(w_en), 32'h0);
    tick();
    #1;
    chk("cap_next_grant", 32'(grant), 32'b1000);
    chk("cap_next_data", 32'(data_in), 32'h44);
    tick();
    req_valid = '0;
    req_last  = '0;
    #1;
    chk("cap_end_grant", 32'(grant), 32'h0);

    // Backpressure after beat 2 for 10 cycles; rr_ptr is 0 here.
    req_valid = 4'b0001;
    req_data[7:0] = 8'h01;
    tick();
    #1;
    chk("bp_grant", 32'(grant), 32'b0001);
    tick();
    req_data[7:0] = 8'h02;
    tick();
    req_data[7:0] = 8'h03;
    full = 1'b1;
    bad  = 0;
    for (int i = 0; i < 10; i++) begin
      #1;
      if (w_en !== 1'b0 || req_ready !== 4'b0000) bad++;
      tick();
    end
    chk("bp_full_quiet", bad, 32'd0);
    full     = 1'b0;
    req_last = 4'b0001;
    #1;
    chk("bp_b3_w_en", 32'(w_en), 32'h1);
    chk("bp_b3_data", 32'(data_in), 32'h03);
    tick();
    req_valid = '0;
    req_last  = '0;
    #1;
    chk("bp_end_grant", 32'(grant), 32'h0);

    // Stall error: requester 1 owns while full is held for 70 edges.
    req_valid = 4'b0010;
    req_data[15:8] = 8'h77;
    tick();
    full = 1'b1;
    #1;
    chk("stall_grant", 32'(grant), 32'b0010);
    rise_at = 0;
    for (int i = 1; i <= 70; i++) begin
      tick();
      #1;
      if (stall_err && rise_at == 0) rise_at = i;
    end
    chk("stall_rise_cycle", rise_at, 32'd64);
    chk("stall_err_held", 32'(stall_err), 32'h1);
    full     = 1'b0;
    req_last = 4'b0010;
    #1;
    chk("stall_drain_w_en", 32'(w_en), 32'h1);
    tick();
    req_valid = '0;
    req_last  = '0;
    err_clr   = 1'b1;
    #1;
    chk("stall_err_before_clr", 32'(stall_err), 32'h1);
    tick();
    err_clr = 1'b0;
    #1;
    chk("stall_err_cleared", 32'(stall_err), 32'h0);

    // Reset in the middle of a 10-beat burst, after beat 5; rr_ptr is 2.
    req_valid = 4'b0001;
    tick();
    #1;
    chk("rmb_grant", 32'(grant), 32'b0001);
    for (int i = 0; i < 5; i++) tick();
    #1;
    chk("rmb_w_en_before", 32'(w_en), 32'h1);
    wrst_n = 1'b0;
    #1;
    chk("rmb_grant_rst", 32'(grant), 32'h0);
    chk("rmb_w_en_rst", 32'(w_en), 32'h0);
    chk("rmb_stall_err_rst", 32'(stall_err), 32'h0);
    chk("rmb_data_rst", 32'(data_in), 32'h0);
    req_valid = 4'b0100;
    tick();
    wrst_n = 1'b1;
    tick();
    #1;
    chk("rmb_edge1_grant", 32'(grant), 32'h0);
    tick();
    #1;
    chk("rmb_regrant", 32'(grant), 32'b0100);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
